// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/result handshake bundle for serial_adder.
//   in_valid / in_ready / a / b      operand handshake (upstream -> adder)
//   out_valid / out_ready / sum / carry  result handshake (adder -> downstream)
// master: the side that supplies operands and consumes results.
// slave:  the adder itself.
interface serial_adder_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] sum;
    logic                  carry;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, sum, carry
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, sum, carry
    );
endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial unsigned adder, LSB first, one bit per clock.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    serial_adder_if.slave: operand handshake (in_valid/in_ready/a/b)
//          and result handshake (out_valid/out_ready/sum/carry)
// One add takes DATA_WIDTH RUN cycles; {carry,sum} == a+b.

// Half-adder cell; purely combinational.
module serial_adder_ha (
    input  logic a_i,
    input  logic b_i,
    output logic s_c_o,
    output logic c_c_o
);
    assign s_c_o = a_i ^ b_i;
    assign c_c_o = a_i & b_i;
endmodule

module serial_adder #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                state_q,     state_d;
    logic [DATA_WIDTH-1:0] a_q,         a_d;
    logic [DATA_WIDTH-1:0] b_q,         b_d;
    logic [DATA_WIDTH-1:0] sum_q,       sum_d;
    logic                  carry_q,     carry_d;
    logic                  c_q,         c_d;
    logic [CNT_W-1:0]      cnt_q,       cnt_d;
    logic                  in_ready_q,  in_ready_d;
    logic                  out_valid_q, out_valid_d;

    logic s0, c0, s_bit, c1, c_next, last_bit;

    // Full-adder slice built from two half-adder cells and an OR.
    serial_adder_ha u_ha0 (.a_i(a_q[0]), .b_i(b_q[0]), .s_c_o(s0),    .c_c_o(c0));
    serial_adder_ha u_ha1 (.a_i(s0),     .b_i(c_q),    .s_c_o(s_bit), .c_c_o(c1));
    assign c_next   = c0 | c1;
    assign last_bit = (cnt_q == CNT_W'(DATA_WIDTH - 1));

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            c_q         <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            c_q         <= c_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        c_d     = c_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                // Sum bit enters at the MSB; after DATA_WIDTH shifts bit 0 sits at the LSB.
                sum_d = (sum_q >> 1) | (DATA_WIDTH'(s_bit) << (DATA_WIDTH - 1));
                c_d   = c_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    carry_d = c_next;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_valid_q && bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Handshake flags track the state register, so no path from in_valid/out_ready.
    always_comb begin
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.carry     = carry_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and random checks of serial_adder at
// DATA_WIDTH=8 and DATA_WIDTH=1, with a scoreboard of expected {carry,sum}.
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_adder_if #(.DATA_WIDTH(8)) if8 ();
    serial_adder_if #(.DATA_WIDTH(1)) if1 ();

    serial_adder #(.DATA_WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
    serial_adder #(.DATA_WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    int tests = 0;
    int fails = 0;
    logic [8:0] q8[$];
    logic [1:0] q1[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present operands at a negedge once ready, accept at the next posedge.
    task automatic send8(input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        while (if8.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send8_ready", 32'(if8.in_ready), 32'd1);
        if8.a = a;
        if8.b = b;
        if8.in_valid = 1'b1;
        @(posedge clk);
        q8.push_back({1'b0, a} + {1'b0, b});
        @(negedge clk);
        if8.in_valid = 1'b0;
    endtask

    // Called at the negedge right after acceptance; exp_lat < 0 skips the latency check.
    task automatic recv8(input int exp_lat);
        int n = 0;
        logic [8:0] e;
        while (if8.out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("out_valid", 32'(if8.out_valid), 32'd1);
        if (exp_lat >= 0) chk("latency8", 32'(n), 32'(exp_lat));
        chk("in_ready_done", 32'(if8.in_ready), 32'd0);
        e = (q8.size() != 0) ? q8.pop_front() : 9'h1FF;
        chk("sum8", 32'(if8.sum), 32'(e[7:0]));
        chk("carry8", 32'(if8.carry), 32'(e[8]));
    endtask

    // One cycle after DONE with out_ready=1 the block is back in IDLE.
    task automatic finish_hs8();
        @(negedge clk);
        chk("hs_out_valid", 32'(if8.out_valid), 32'd0);
        chk("hs_in_ready", 32'(if8.in_ready), 32'd1);
    endtask

    task automatic op1(input logic a, input logic b);
        int n = 0;
        logic [1:0] e;
        @(negedge clk);
        while (if1.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("send1_ready", 32'(if1.in_ready), 32'd1);
        if1.a = a;
        if1.b = b;
        if1.in_valid = 1'b1;
        @(posedge clk);
        q1.push_back({1'b0, a} + {1'b0, b});
        @(negedge clk);
        if1.in_valid = 1'b0;
        n = 0;
        while (if1.out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency1", 32'(n), 32'd1);
        e = (q1.size() != 0) ? q1.pop_front() : 2'b11;
        chk("sum1", 32'(if1.sum), 32'(e[0]));
        chk("carry1", 32'(if1.carry), 32'(e[1]));
        @(negedge clk);
        chk("hs1_in_ready", 32'(if1.in_ready), 32'd1);
    endtask

    initial begin
        if8.in_valid = 1'b0; if8.a = '0; if8.b = '0; if8.out_ready = 1'b0;
        if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.out_ready = 1'b1;

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(if8.in_ready), 32'd1);
        chk("rst_out_valid", 32'(if8.out_valid), 32'd0);
        chk("rst_sum", 32'(if8.sum), 32'd0);
        chk("rst_carry", 32'(if8.carry), 32'd0);
        rst_n = 1'b1;

        // Basic adds with immediate result acceptance.
        if8.out_ready = 1'b1;
        send8(8'h5A, 8'h33);
        chk("in_ready_run", 32'(if8.in_ready), 32'd0);
        recv8(8);
        finish_hs8();
        send8(8'hFF, 8'h01);
        recv8(8);
        finish_hs8();
        send8(8'hFF, 8'hFF);
        recv8(8);
        finish_hs8();

        // Back-pressure in DONE, then simultaneous out_ready and new in_valid.
        if8.out_ready = 1'b0;
        send8(8'hC3, 8'h7E);
        recv8(8);
        repeat (5) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(if8.out_valid), 32'd1);
            chk("bp_sum", 32'(if8.sum), 32'h41);
            chk("bp_carry", 32'(if8.carry), 32'd1);
            chk("bp_in_ready", 32'(if8.in_ready), 32'd0);
        end
        if8.a = 8'h01;
        if8.b = 8'h02;
        if8.in_valid = 1'b1;
        if8.out_ready = 1'b1;
        @(negedge clk);
        chk("sim_out_valid", 32'(if8.out_valid), 32'd0);
        chk("sim_in_ready", 32'(if8.in_ready), 32'd1);
        @(posedge clk);
        q8.push_back(9'h003);
        @(negedge clk);
        if8.in_valid = 1'b0;
        recv8(8);
        finish_hs8();

        // Operands offered during RUN are ignored.
        send8(8'h12, 8'h34);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if8.in_valid = (i % 2 == 0);
            if8.a = 8'($urandom);
            if8.b = 8'($urandom);
            chk("busy_in_ready", 32'(if8.in_ready), 32'd0);
        end
        if8.in_valid = 1'b0;
        recv8(-1);
        finish_hs8();

        // Reset during the 4th RUN cycle aborts the add.
        send8(8'h5A, 8'h33);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(if8.out_valid), 32'd0);
        chk("abort_sum", 32'(if8.sum), 32'd0);
        chk("abort_carry", 32'(if8.carry), 32'd0);
        chk("abort_in_ready", 32'(if8.in_ready), 32'd1);
        q8.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send8(8'h10, 8'h20);
        recv8(8);
        finish_hs8();

        // DATA_WIDTH=1.
        op1(1'b1, 1'b1);
        op1(1'b1, 1'b0);
        op1(1'b0, 1'b1);
        op1(1'b0, 1'b0);

        // Random operands against the a+b reference.
        for (int i = 0; i < 1000; i++) begin
            send8(8'($urandom), 8'($urandom));
            recv8(8);
            finish_hs8();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
